// File: rtl/tone_synth.sv
// Period-synchronous tone synthesizer: a 256-step phase accumulator, advanced every
// activePrescale clocks, drives square/triangle/sawtooth PCM with click-free pitch and mute changes.
module tone_synth #(
    parameter logic [15:0] AMPLITUDE = 16'h2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  preScaleValue,
    input  logic [1:0]  waveSelect,
    output logic [15:0] audioOut,
    output logic        toneActive,
    output logic        phaseWrap
);

    typedef enum logic [1:0] {IDLE, PLAYING, DRAINING} state_t;

    state_t             state_q, state_d;
    logic        [9:0]  active_prescale_q, active_prescale_d;
    logic        [1:0]  active_wave_q, active_wave_d;
    logic        [9:0]  prescale_cnt_q, prescale_cnt_d;
    logic        [7:0]  phase_q, phase_d;
    logic        [15:0] audio_out_q, audio_out_d;
    logic               phase_wrap_q, phase_wrap_d;

    logic               req;
    logic               step_tick;
    logic               wrap_tick;
    logic        [7:0]  saw8;
    logic        [6:0]  tri_t;
    logic        [8:0]  tri9;
    logic signed [24:0] amp_ext;
    logic signed [24:0] mult_a;
    logic signed [24:0] prod;
    logic        [15:0] sample;
    logic               unused_prod_bits;

    assign req       = (preScaleValue != 10'd0);
    assign step_tick = (state_q != IDLE) && (prescale_cnt_q == active_prescale_q - 10'd1);
    assign wrap_tick = step_tick && (phase_q == 8'hFF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= IDLE;
            active_prescale_q <= 10'd0;
            active_wave_q     <= 2'd0;
            prescale_cnt_q    <= 10'd0;
            phase_q           <= 8'd0;
            audio_out_q       <= 16'd0;
            phase_wrap_q      <= 1'b0;
        end else begin
            state_q           <= state_d;
            active_prescale_q <= active_prescale_d;
            active_wave_q     <= active_wave_d;
            prescale_cnt_q    <= prescale_cnt_d;
            phase_q           <= phase_d;
            audio_out_q       <= audio_out_d;
            phase_wrap_q      <= phase_wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (req) state_d = PLAYING;
            PLAYING: begin
                if (wrap_tick)  state_d = req ? PLAYING : IDLE;
                else if (!req)  state_d = DRAINING;
            end
            DRAINING: begin
                if (wrap_tick)  state_d = req ? PLAYING : IDLE;
                else if (req)   state_d = PLAYING;
            end
            default:  state_d = IDLE;
        endcase
    end

    // Waveform generation; one shared multiplier serves triangle and sawtooth.
    always_comb begin
        saw8    = phase_q ^ 8'h80;
        tri_t   = phase_q[7] ? ~phase_q[6:0] : phase_q[6:0];
        tri9    = {1'b0, tri_t, 1'b0} - 9'd127;
        amp_ext = {9'd0, AMPLITUDE};
        mult_a  = 25'sd0;
        case (active_wave_q)
            2'd1:    mult_a = {{16{tri9[8]}}, tri9};
            2'd2:    mult_a = {{17{saw8[7]}}, saw8};
            default: mult_a = 25'sd0;
        endcase
        prod = mult_a * amp_ext;
        case (active_wave_q)
            2'd0:    sample = phase_q[7] ? (~AMPLITUDE + 16'd1) : AMPLITUDE;
            2'd1,
            2'd2:    sample = prod[22:7];
            default: sample = 16'd0;
        endcase
    end

    assign unused_prod_bits = ^{prod[24:23], prod[6:0]};

    always_comb begin
        active_prescale_d = active_prescale_q;
        active_wave_d     = active_wave_q;
        prescale_cnt_d    = prescale_cnt_q;
        phase_d           = phase_q;
        phase_wrap_d      = wrap_tick;
        audio_out_d       = (state_q == IDLE) ? 16'd0 : sample;

        if (req && ((state_q == IDLE) || wrap_tick)) begin
            active_prescale_d = preScaleValue;
            active_wave_d     = waveSelect;
        end

        if (state_q == IDLE) begin
            prescale_cnt_d = 10'd0;
            phase_d        = 8'd0;
        end else if (step_tick) begin
            prescale_cnt_d = 10'd0;
            phase_d        = phase_q + 8'd1;
        end else begin
            prescale_cnt_d = prescale_cnt_q + 10'd1;
        end
    end

    assign audioOut   = audio_out_q;
    assign toneActive = (state_q != IDLE);
    assign phaseWrap  = phase_wrap_q;

endmodule

// File: tb/tb_tone_synth.sv
// Directed bench for tone_synth: a table of per-phase sample checks plus hand-written
// sequences for start/stop latency, pitch change, mute/drain and asynchronous reset.
module tb_tone_synth;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  psv;
    logic [1:0]  ws;
    logic [15:0] audioOut;
    logic        toneActive;
    logic        phaseWrap;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0]  wave;
        int          p;
        logic [15:0] audio;
        logic        wrap;
    } vec_t;

    vec_t vecs[14];

    tone_synth #(.AMPLITUDE(16'h2000)) dut (
        .clk(clk),
        .reset(reset),
        .preScaleValue(psv),
        .waveSelect(ws),
        .audioOut(audioOut),
        .toneActive(toneActive),
        .phaseWrap(phaseWrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        psv   = 10'd0;
        ws    = 2'd0;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    task automatic start_tone(input logic [9:0] p, input logic [1:0] w);
        psv = p;
        ws  = w;
        step(1);
    endtask

    task automatic wait_wrap(input int max, output int n);
        n = 0;
        while (n < max) begin
            step(1);
            n++;
            if (phaseWrap) return;
        end
    endtask

    initial begin
        int n;
        int bad_a;
        int bad_w;
        int wraps;
        logic [15:0] exp_a;

        // Samples seen one clock after the phase reaches p (preScaleValue = 1).
        vecs[0]  = '{2'd2, 0,   16'hE000, 1'b0};
        vecs[1]  = '{2'd2, 64,  16'hF000, 1'b0};
        vecs[2]  = '{2'd2, 128, 16'h0000, 1'b0};
        vecs[3]  = '{2'd2, 255, 16'h1FC0, 1'b1};
        vecs[4]  = '{2'd1, 0,   16'hE040, 1'b0};
        vecs[5]  = '{2'd1, 64,  16'h0040, 1'b0};
        vecs[6]  = '{2'd1, 127, 16'h1FC0, 1'b0};
        vecs[7]  = '{2'd1, 128, 16'h1FC0, 1'b0};
        vecs[8]  = '{2'd1, 255, 16'hE040, 1'b1};
        vecs[9]  = '{2'd0, 0,   16'h2000, 1'b0};
        vecs[10] = '{2'd0, 127, 16'h2000, 1'b0};
        vecs[11] = '{2'd0, 128, 16'hE000, 1'b0};
        vecs[12] = '{2'd0, 255, 16'hE000, 1'b1};
        vecs[13] = '{2'd3, 100, 16'h0000, 1'b0};

        reset = 1'b1;
        psv   = 10'd0;
        ws    = 2'd0;
        @(negedge clk);
        do_reset();
        check("reset_audio", audioOut, 16'h0000);
        check("reset_active", toneActive, 1'b0);
        check("reset_wrap", phaseWrap, 1'b0);

        for (int i = 0; i < 14; i++) begin
            do_reset();
            start_tone(10'd1, vecs[i].wave);
            step(vecs[i].p + 1);
            check($sformatf("vec%0d_audio", i), audioOut, vecs[i].audio);
            check($sformatf("vec%0d_wrap", i), phaseWrap, vecs[i].wrap);
            check($sformatf("vec%0d_active", i), toneActive, 1'b1);
        end

        // Square, preScaleValue = 4: 512 clocks high, 512 low, wrap every 1024.
        do_reset();
        start_tone(10'd4, 2'd0);
        check("sq_start_active", toneActive, 1'b1);
        check("sq_start_audio", audioOut, 16'h0000);
        bad_a = 0;
        bad_w = 0;
        for (int k = 1; k <= 2048; k++) begin
            step(1);
            exp_a = (((k - 1) % 1024) < 512) ? 16'h2000 : 16'hE000;
            if (audioOut !== exp_a) bad_a++;
            if (phaseWrap !== ((k % 1024) == 0)) bad_w++;
        end
        check("sq_audio_errors", bad_a, 0);
        check("sq_wrap_errors", bad_w, 0);

        // Pitch and waveform change mid-period take effect only from the wrap.
        do_reset();
        start_tone(10'd4, 2'd0);
        step(100);
        psv = 10'd2;
        ws  = 2'd2;
        step(1);
        check("pitch_old_wave", audioOut, 16'h2000);
        wait_wrap(973, n);
        check("pitch_first_period", n, 923);
        check("pitch_wrap_audio", audioOut, 16'hE000);
        check("pitch_wrap_active", toneActive, 1'b1);
        step(129);
        check("pitch_new_wave", audioOut, 16'hF000);
        wait_wrap(433, n);
        check("pitch_second_period", n, 383);

        // Mute drains to the wrap, then goes idle.
        do_reset();
        start_tone(10'd4, 2'd0);
        step(200);
        psv = 10'd0;
        step(1);
        check("mute_draining_active", toneActive, 1'b1);
        check("mute_draining_audio", audioOut, 16'h2000);
        wait_wrap(873, n);
        check("mute_wrap_time", n, 823);
        check("mute_wrap_active", toneActive, 1'b0);
        check("mute_wrap_audio", audioOut, 16'hE000);
        step(1);
        check("mute_idle_audio", audioOut, 16'h0000);
        check("mute_idle_wrap", phaseWrap, 1'b0);
        wraps = 0;
        bad_a = 0;
        for (int k = 0; k < 300; k++) begin
            step(1);
            if (phaseWrap) wraps++;
            if (audioOut !== 16'h0000 || toneActive !== 1'b0) bad_a++;
        end
        check("mute_idle_stays_quiet", bad_a, 0);
        check("mute_idle_no_wraps", wraps, 0);

        // Re-request before the wrap keeps the tone continuous.
        do_reset();
        start_tone(10'd4, 2'd0);
        step(200);
        psv = 10'd0;
        step(100);
        psv = 10'd4;
        wait_wrap(774, n);
        check("rereq_wrap_time", n, 724);
        check("rereq_wrap_active", toneActive, 1'b1);
        step(1);
        check("rereq_audio", audioOut, 16'h2000);

        // Silent waveform: counters still run.
        do_reset();
        start_tone(10'd1, 2'd3);
        bad_a = 0;
        bad_w = 0;
        wraps = 0;
        for (int k = 1; k <= 512; k++) begin
            step(1);
            if (audioOut !== 16'h0000) bad_a++;
            if (phaseWrap !== ((k % 256) == 0)) bad_w++;
            if (phaseWrap) wraps++;
        end
        check("silent_audio_errors", bad_a, 0);
        check("silent_wrap_errors", bad_w, 0);
        check("silent_wrap_count", wraps, 2);

        // Asynchronous reset asserted mid-tone while phaseWrap is high.
        do_reset();
        start_tone(10'd1, 2'd0);
        step(256);
        check("rst_pre_wrap", phaseWrap, 1'b1);
        check("rst_pre_active", toneActive, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check("rst_async_audio", audioOut, 16'h0000);
        check("rst_async_active", toneActive, 1'b0);
        check("rst_async_wrap", phaseWrap, 1'b0);
        psv = 10'd0;
        @(negedge clk);
        reset = 1'b0;
        step(20);
        check("rst_after_audio", audioOut, 16'h0000);
        check("rst_after_active", toneActive, 1'b0);
        check("rst_after_wrap", phaseWrap, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
